// File: rtl/instruction_fetch.sv
// Fetch stage ahead of the instruction decoder. It owns the program counter,
// reads opcodes (plus an immediate word after LDI) from program memory over a
// req/valid handshake, and offers each instruction to execute over valid/ready.
// When the decoder reports that the accepted instruction is RST, the program
// restarts at address 0. Every output comes from a register or is decoded from
// the FSM state, so there is no combinational path from an input to an output.
module instruction_fetch #(
  parameter int                     INSTR_WIDTH = 4,
  parameter int                     ADDR_WIDTH  = 4,
  parameter int                     DATA_WIDTH  = 4,
  parameter logic [INSTR_WIDTH-1:0] LDI_OPCODE  = 4'hD,
  parameter logic [INSTR_WIDTH-1:0] NOP_OPCODE  = 4'hC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   pm_req,
  output logic [ADDR_WIDTH-1:0]  pm_addr,
  input  logic [INSTR_WIDTH-1:0] pm_data,
  input  logic                   pm_valid,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0]  imm,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   reset_instr,
  output logic [ADDR_WIDTH-1:0]  pc
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FETCH_IMM,
    ISSUE
  } state_t;

  state_t                 state, state_next;
  logic [INSTR_WIDTH-1:0] ir, ir_next;
  logic [DATA_WIDTH-1:0]  imm_q, imm_next;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_next;

  // State, instruction, immediate and PC registers; reset aborts any fetch or issue in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ir    <= NOP_OPCODE;
      imm_q <= '0;
      pc_q  <= '0;
    end else begin
      state <= state_next;
      ir    <= ir_next;
      imm_q <= imm_next;
      pc_q  <= pc_next;
    end
  end

  // Next state and register updates; memory data is taken only while a request is outstanding.
  always_comb begin
    state_next = state;
    ir_next    = ir;
    imm_next   = imm_q;
    pc_next    = pc_q;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (pm_valid) begin
          ir_next    = pm_data;
          pc_next    = pc_q + ADDR_WIDTH'(1);
          state_next = (pm_data == LDI_OPCODE) ? FETCH_IMM : ISSUE;
        end
      end
      FETCH_IMM: begin
        if (pm_valid) begin
          imm_next   = DATA_WIDTH'(pm_data);
          pc_next    = pc_q + ADDR_WIDTH'(1);
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) begin
          if (reset_instr) begin
            pc_next = '0;
          end
          state_next = en ? FETCH : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign pm_req      = (state == FETCH) || (state == FETCH_IMM);
  assign pm_addr     = pc_q;
  assign instr_valid = (state == ISSUE);
  assign instruction = (state == ISSUE) ? ir : NOP_OPCODE;
  assign imm         = imm_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch. A program-memory responder with
// random latency feeds the fetch stage. A reference model walks the program in
// memory the way execute should see it and checks every offered instruction,
// every memory address and the PC against that walk.
module tb_instruction_fetch;

  localparam logic [3:0] LDI_OP = 4'hD;
  localparam logic [3:0] NOP_OP = 4'hC;
  localparam logic [3:0] RST_OP = 4'hE;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       pm_req;
  logic [3:0] pm_addr;
  logic [3:0] pm_data;
  logic       pm_valid;
  logic [3:0] instruction;
  logic [3:0] imm;
  logic       instr_valid;
  logic       instr_ready;
  logic       reset_instr;
  logic [3:0] pc;

  logic [3:0] mem [16];
  int         min_lat;
  int         max_lat;
  int         wcnt;
  int         lat;
  logic       noise_v;
  logic [3:0] noise_d;

  logic [3:0] mpc;
  logic [3:0] mread;
  logic [3:0] mimm;
  int         issued;

  int checks   = 0;
  int failures = 0;

  instruction_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pm_req      (pm_req),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .pm_valid    (pm_valid),
    .instruction (instruction),
    .imm         (imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .reset_instr (reset_instr),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  // Memory answers after a random latency; while no request is open it shows random noise.
  assign pm_valid    = pm_req ? (wcnt >= lat) : noise_v;
  assign pm_data     = pm_req ? mem[pm_addr] : noise_d;
  assign reset_instr = instr_valid && (instruction == RST_OP);

  // Latency counter for the current memory request and fresh noise each cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      lat  <= $urandom_range(max_lat, min_lat);
    end else if (pm_req && pm_valid) begin
      wcnt <= 0;
      lat  <= $urandom_range(max_lat, min_lat);
    end else if (pm_req) begin
      wcnt <= wcnt + 1;
    end
    noise_v <= 1'($urandom_range(1, 0));
    noise_d <= 4'($urandom_range(15, 0));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference walk of the program: what execute should see next, and which address is read next.
  always @(negedge clk) begin
    logic [3:0] op;
    logic [3:0] npc;
    logic [3:0] nimm;
    if (!rst_n) begin
      mpc    <= 4'h0;
      mread  <= 4'h0;
      mimm   <= 4'h0;
      issued <= 0;
    end else begin
      if (pm_req) begin
        checkOutput("pm_addr", pm_addr, mread);
        if (pm_valid) begin
          mread <= mread + 4'h1;
        end
      end
      if (instr_valid) begin
        op   = mem[mpc];
        npc  = mpc + 4'h1;
        nimm = mimm;
        if (op == LDI_OP) begin
          nimm = mem[npc];
          npc  = npc + 4'h1;
        end
        checkOutput("issue_op", instruction, op);
        checkOutput("issue_imm", imm, nimm);
        checkOutput("issue_pc", pc, npc);
        if (instr_ready) begin
          issued <= issued + 1;
          mimm   <= nimm;
          if (op == RST_OP) begin
            mpc   <= 4'h0;
            mread <= 4'h0;
          end else begin
            mpc <= npc;
          end
        end
      end else begin
        checkOutput("nop_out", instruction, NOP_OP);
      end
    end
  end

  task automatic applyStimulus(input logic e, input logic r);
    @(posedge clk);
    #1;
    en          = e;
    instr_ready = r;
  endtask

  task automatic doReset(input logic e);
    rst_n       = 1'b0;
    en          = 1'b0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_pm_req", pm_req, 1'b0);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_instr", instruction, NOP_OP);
    checkOutput("rst_pc", pc, 4'h0);
    checkOutput("rst_imm", imm, 4'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = e;
  endtask

  initial begin
    bit found;
    int cyc;
    rst_n       = 1'b0;
    en          = 1'b0;
    instr_ready = 1'b0;
    min_lat     = 0;
    max_lat     = 0;

    // Straight line, LDI and RST with zero-wait memory and execute always ready.
    for (int i = 0; i < 16; i++) mem[i] = 4'h1;
    mem[0] = 4'h5; mem[1] = 4'h9; mem[2] = LDI_OP; mem[3] = 4'h7; mem[4] = RST_OP;
    $display("[TB] directed program: 5, 9, LDI 7, RST");
    doReset(1'b1);
    repeat (10) applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("dir_issued", issued, 4);
    checkOutput("dir_refetch_req", pm_req, 1'b1);
    checkOutput("dir_refetch_addr", pm_addr, 4'h0);
    checkOutput("dir_refetch_pc", pc, 4'h0);

    // Asynchronous reset while waiting on the immediate word.
    $display("[TB] async reset during immediate fetch");
    mem[0] = LDI_OP; mem[1] = 4'h7;
    min_lat = 3; max_lat = 3;
    doReset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      if (pm_req && pc == 4'h1) found = 1'b1;
    end
    checkOutput("ar_reach_imm", found, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_pm_req", pm_req, 1'b0);
    checkOutput("ar_valid", instr_valid, 1'b0);
    checkOutput("ar_instr", instruction, NOP_OP);
    checkOutput("ar_pc", pc, 4'h0);
    checkOutput("ar_pm_addr", pm_addr, 4'h0);

    // Random programs, memory latency, execute stalls and run-enable gaps.
    for (int round = 0; round < 3; round++) begin
      $display("[TB] random round %0d", round);
      for (int i = 0; i < 16; i++) mem[i] = 4'($urandom_range(15, 0));
      min_lat = 0;
      max_lat = 3;
      doReset(1'b1);
      cyc = 0;
      while (issued < 60 && cyc < 3000) begin
        applyStimulus(($urandom_range(99, 0) < 90), ($urandom_range(99, 0) < 65));
        cyc++;
      end
      @(negedge clk);
      checkOutput("rand_progress", (issued >= 60), 1'b1);
    end

    // PC wrap with an LDI at the top address, run enable dropped during the immediate fetch.
    $display("[TB] wrap with LDI at top address and enable drop");
    for (int i = 0; i < 16; i++) mem[i] = 4'h1;
    mem[0]  = 4'h3;
    mem[15] = LDI_OP;
    min_lat = 0;
    max_lat = 0;
    doReset(1'b1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      applyStimulus(1'b1, 1'b1);
      @(negedge clk);
      if (pm_req && pc == 4'h0 && issued == 15) found = 1'b1;
    end
    checkOutput("wrap_reach_imm", found, 1'b1);
    en = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("wrap_issued", issued, 16);
    checkOutput("wrap_idle_valid", instr_valid, 1'b0);
    checkOutput("wrap_idle_instr", instruction, NOP_OP);
    checkOutput("wrap_idle_req", pm_req, 1'b0);
    checkOutput("wrap_pc", pc, 4'h1);
    checkOutput("wrap_imm", imm, 4'h3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
